// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op-class/function encodings and FSM states shared by the ALU and its bench
package alu_seq_pkg;
  typedef enum logic [1:0] {CL_ARITH = 2'b00, CL_LOGIC = 2'b01, CL_SHIFT = 2'b10, CL_MUL = 2'b11} cls_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10} state_e;
  localparam logic [2:0] FN_ADD  = 3'd0;
  localparam logic [2:0] FN_SUB  = 3'd1;
  localparam logic [2:0] FN_INC  = 3'd2;
  localparam logic [2:0] FN_DEC  = 3'd3;
  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_OR   = 3'd1;
  localparam logic [2:0] FN_XOR  = 3'd2;
  localparam logic [2:0] FN_NOR  = 3'd3;
  localparam logic [2:0] FN_NOT  = 3'd4;
  localparam logic [2:0] FN_NAND = 3'd5;
  localparam logic [2:0] FN_XNOR = 3'd6;
  localparam logic [2:0] FN_PASS = 3'd7;
  localparam logic [2:0] FN_SLL  = 3'd0;
  localparam logic [2:0] FN_SRL  = 3'd1;
  localparam logic [2:0] FN_SRA  = 3'd2;
  localparam logic [2:0] FN_ROL  = 3'd3;
  localparam logic [2:0] FN_ROR  = 3'd4;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle for WIDTH cycles
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  // done and product reflect the step being taken this cycle, so the caller sees no extra latency
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = run_q & (cnt_q == CW'(1));
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
      run_d    = 1'b1;
    end else if (run_q) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = product;
      cnt_d    = cnt_q - 1'b1;
      run_d    = !done;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle arith/logic and multi-cycle shift/multiply
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SHIFT_ITER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       functionals,
  input  logic [2:0]       logicfn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             zeroflag,
  output logic             msb,
  output logic             overflow,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  // one shift/rotate step, returned as {bit shifted out, new data}
  function automatic logic [WIDTH:0] shift_step(input logic [2:0] fn, input logic [WIDTH-1:0] d);
    return fn == FN_SLL ? {d, 1'b0} :
           fn == FN_SRL ? {d[0], 1'b0, d[WIDTH-1:1]} :
           fn == FN_SRA ? {d[0], d[WIDTH-1], d[WIDTH-1:1]} :
           fn == FN_ROL ? {d, d[WIDTH-1]} :
                          {d[0], d[0], d[WIDTH-1:1]};
  endfunction
  function automatic logic [WIDTH:0] shift_n(input logic [2:0] fn, input logic [WIDTH-1:0] a,
                                             input logic [SHW-1:0] k);
    logic [WIDTH:0] r;
    r = {1'b0, a};
    for (int i = 0; i < 2**SHW; i++) r = (i < int'(k)) ? shift_step(fn, r[WIDTH-1:0]) : r;
    return r;
  endfunction
  // single-cycle result as {overflow, carry, value}; MUL never goes through here
  function automatic logic [WIDTH+1:0] compute(input cls_e c, input logic [2:0] fn,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] opb, r;
    logic [WIDTH:0]   s;
    logic [SHW-1:0]   k;
    logic             cy, ov;
    opb = fn[1] ? WIDTH'(1) : b;
    s   = fn[0] ? {1'b0, a} - {1'b0, opb} : {1'b0, a} + {1'b0, opb};
    k   = SHIFT_ITER ? '0 : b[SHW-1:0];
    r   = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    case (c)
      CL_ARITH: if (!fn[2]) begin
        r  = s[WIDTH-1:0];
        cy = s[WIDTH];
        ov = (fn[0] ? (a[WIDTH-1] != opb[WIDTH-1]) : (a[WIDTH-1] == opb[WIDTH-1])) &
             (s[WIDTH-1] != a[WIDTH-1]);
      end
      CL_LOGIC: r = fn == FN_AND  ? a & b :
                    fn == FN_OR   ? a | b :
                    fn == FN_XOR  ? a ^ b :
                    fn == FN_NOR  ? ~(a | b) :
                    fn == FN_NOT  ? ~a :
                    fn == FN_NAND ? ~(a & b) :
                    fn == FN_XNOR ? ~(a ^ b) : b;
      CL_SHIFT: if (fn <= FN_ROR) {cy, r} = shift_n(fn, a, k);
      default: ;
    endcase
    return {ov, cy, r};
  endfunction
  state_e             state_q, state_d;
  cls_e               cls_q, cls_d;
  logic [2:0]         fn_q, fn_d;
  logic [WIDTH-1:0]   sh_q, sh_d, value_q, value_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               carry_q, carry_d, zero_q, zero_d, msb_q, msb_d, ovf_q, ovf_d;
  logic               accept, iter_op, load, mul_done;
  logic [WIDTH+1:0]   single_r, res_d;
  logic [WIDTH:0]     step_r;
  logic [2*WIDTH-1:0] mul_prod;
  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign iter_op   = (functionals == CL_MUL) |
                     (SHIFT_ITER & (functionals == CL_SHIFT) & (logicfn <= FN_ROR) & |y[SHW-1:0]);
  assign single_r  = compute(cls_e'(functionals), logicfn, x, y);
  assign step_r    = shift_step(fn_q, sh_q);
  assign out_valid = state_q == S_DONE;
  assign busy      = state_q == S_BUSY;
  assign value     = value_q;
  assign carry     = carry_q;
  assign zeroflag  = zero_q;
  assign msb       = msb_q;
  assign overflow  = ovf_q;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept & (functionals == CL_MUL)),
    .a       (x),
    .b       (y),
    .done    (mul_done),
    .product (mul_prod)
  );
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    fn_d    = fn_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    res_d   = single_r;
    if (accept) begin
      cls_d   = cls_e'(functionals);
      fn_d    = logicfn;
      sh_d    = x;
      cnt_d   = y[SHW-1:0];
      state_d = iter_op ? S_BUSY : S_DONE;
      load    = !iter_op;
    end else if ((state_q == S_DONE) & out_ready) begin
      state_d = S_IDLE;
    end else if (state_q == S_BUSY) begin
      if (cls_q == CL_MUL) begin
        load  = mul_done;
        res_d = {{2{|mul_prod[2*WIDTH-1:WIDTH]}}, mul_prod[WIDTH-1:0]};
      end else begin
        sh_d  = step_r[WIDTH-1:0];
        cnt_d = cnt_q - 1'b1;
        load  = cnt_q == SHW'(1);
        res_d = {1'b0, step_r};
      end
      state_d = load ? S_DONE : S_BUSY;
    end
    value_d = load ? res_d[WIDTH-1:0] : value_q;
    carry_d = load ? res_d[WIDTH] : carry_q;
    ovf_d   = load ? res_d[WIDTH+1] : ovf_q;
    zero_d  = load ? ~|res_d[WIDTH-1:0] : zero_q;
    msb_d   = load ? res_d[WIDTH-1] : msb_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= CL_ARITH;
      fn_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      msb_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      fn_q    <= fn_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      msb_q   <= msb_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
